trap_ctrl: RTL and testbench

//  Trap/return sequencer directly downstream of the machine-mode CSR unit.

---
 rtl/trap_ctrl_pkg.sv | 18 +
 rtl/trap_ctrl_if.sv | 11 +
 rtl/trap_ctrl.sv | 134 +++++++++++++
 tb/tb_trap_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the trap/return sequencer: FSM states and redirect kind.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    TRAP_IDLE  = 2'd0,
    TRAP_FLUSH = 2'd1,
    TRAP_REDIR = 2'd2,
    TRAP_HALT  = 2'd3
  } trap_state_t;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_RET  = 1'b1
  } trap_kind_t;

  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/trap_ctrl_if.sv
// Redirect handshake from the trap sequencer towards fetch.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: flushes younger work, then hands one redirect PC to fetch.
// Tracks handler nesting and halts on a trap taken inside a handler.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ex,
  input  logic             i_eret,
  input  logic [XLEN-1:0]  i_tvec,
  input  logic [XLEN-1:0]  i_epc,
  input  logic [XLEN-1:0]  i_cause,
  trap_ctrl_if.master      redir,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_trap_taken,
  output logic [XLEN-1:0]  o_cause_q,
  output logic             o_in_handler,
  output logic             o_halt,
  output logic [CNT_W-1:0] o_trap_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0]        ALIGN_MASK = ~(XLEN'(3));

  trap_state_t            state_reg, state_next;
  trap_kind_t             kind_reg, kind_next;
  logic [FLUSH_CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic [XLEN-1:0]        target_reg, target_next;
  logic [XLEN-1:0]        cause_reg, cause_next;
  logic                   in_handler_reg, in_handler_next;
  logic                   trap_taken_reg, trap_taken_next;
  logic [CNT_W-1:0]       trap_count_reg, trap_count_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_reg      <= TRAP_IDLE;
      kind_reg       <= KIND_TRAP;
      flush_cnt_reg  <= '0;
      target_reg     <= '0;
      cause_reg      <= '0;
      in_handler_reg <= 1'b0;
      trap_taken_reg <= 1'b0;
      trap_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      kind_reg       <= kind_next;
      flush_cnt_reg  <= flush_cnt_next;
      target_reg     <= target_next;
      cause_reg      <= cause_next;
      in_handler_reg <= in_handler_next;
      trap_taken_reg <= trap_taken_next;
      trap_count_reg <= trap_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    kind_next       = kind_reg;
    flush_cnt_next  = flush_cnt_reg;
    target_next     = target_reg;
    cause_next      = cause_reg;
    in_handler_next = in_handler_reg;
    trap_taken_next = 1'b0;
    trap_count_next = trap_count_reg;

    case (state_reg)
      TRAP_IDLE: begin
        // A trap wins over a simultaneous mret; a trap inside a handler is fatal.
        if (i_ex) begin
          if (in_handler_reg) begin
            state_next = TRAP_HALT;
          end else begin
            target_next    = i_tvec & ALIGN_MASK;
            kind_next      = KIND_TRAP;
            cause_next     = i_cause;
            flush_cnt_next = FLUSH_LOAD;
            state_next     = TRAP_FLUSH;
          end
        end else if (i_eret) begin
          target_next    = i_epc & ALIGN_MASK;
          kind_next      = KIND_RET;
          flush_cnt_next = FLUSH_LOAD;
          state_next     = TRAP_FLUSH;
        end
      end
      TRAP_FLUSH: begin
        if (flush_cnt_reg == '0) begin
          state_next = TRAP_REDIR;
        end else begin
          flush_cnt_next = flush_cnt_reg - 1'b1;
        end
      end
      TRAP_REDIR: begin
        if (redir.redirect_ready) begin
          state_next = TRAP_IDLE;
          if (kind_reg == KIND_TRAP) begin
            trap_taken_next = 1'b1;
            in_handler_next = 1'b1;
            if (trap_count_reg != '1) begin
              trap_count_next = trap_count_reg + 1'b1;
            end
          end else begin
            in_handler_next = 1'b0;
          end
        end
      end
      TRAP_HALT: begin
        state_next = TRAP_HALT;
      end
      default: begin
        state_next = TRAP_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decode from state; the rest come from registers.
  always_comb begin
    o_stall              = (state_reg != TRAP_IDLE);
    o_flush              = (state_reg == TRAP_FLUSH);
    o_halt               = (state_reg == TRAP_HALT);
    redir.redirect_valid = (state_reg == TRAP_REDIR);
    redir.redirect_pc    = target_reg;
    o_trap_taken         = trap_taken_reg;
    o_cause_q            = cause_reg;
    o_in_handler         = in_handler_reg;
    o_trap_count         = trap_count_reg;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized self-checking bench for trap_ctrl against a transaction-level model.
module tb_trap_ctrl;

  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ex = 1'b0, eret = 1'b0;
  logic [XLEN-1:0] tvec = '0, epc = '0, cause = '0;
  logic            stall, flush, trap_taken, in_handler, halt;
  logic [XLEN-1:0] cause_q;
  logic [CW-1:0]   trap_count;

  int checks = 0;
  int errors = 0;

  // Reference model state, updated per completed transaction.
  logic            m_in_handler = 1'b0;
  int              m_count      = 0;
  logic [XLEN-1:0] m_cause      = '0;

  trap_ctrl_if #(.XLEN(XLEN)) redir ();

  trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ex         (ex),
    .i_eret       (eret),
    .i_tvec       (tvec),
    .i_epc        (epc),
    .i_cause      (cause),
    .redir        (redir),
    .o_stall      (stall),
    .o_flush      (flush),
    .o_trap_taken (trap_taken),
    .o_cause_q    (cause_q),
    .o_in_handler (in_handler),
    .o_halt       (halt),
    .o_trap_count (trap_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic garbage();
    ex    = 1'($urandom);
    eret  = 1'($urandom);
    tvec  = $urandom;
    epc   = $urandom;
    cause = $urandom;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_stall"}, 32'(stall), 32'd0);
    check_eq({tag, "_flush"}, 32'(flush), 32'd0);
    check_eq({tag, "_valid"}, 32'(redir.redirect_valid), 32'd0);
    check_eq({tag, "_halt"},  32'(halt), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ex = 1'b0; eret = 1'b0; redir.redirect_ready = 1'b0;
    @(negedge clk);
    m_in_handler = 1'b0; m_count = 0; m_cause = '0;
    check_idle_outputs("rst");
    check_eq("rst_taken", 32'(trap_taken), 32'd0);
    check_eq("rst_inh",   32'(in_handler), 32'd0);
    check_eq("rst_cnt",   32'(trap_count), 32'd0);
    check_eq("rst_cause", cause_q, 32'd0);
    check_eq("rst_pc",    redir.redirect_pc, 32'd0);
    rst = 1'b1;
    $display("reset done t=%0t", $time);
  endtask

  // One IDLE-launched transaction: idle, trap, mret, or double fault.
  task automatic run_event(input logic ex_v, input logic eret_v, input logic [XLEN-1:0] tvec_v,
                           input logic [XLEN-1:0] epc_v, input logic [XLEN-1:0] cause_v, input int delay);
    logic            is_trap;
    logic [XLEN-1:0] exp_pc;
    @(negedge clk);
    ex = ex_v; eret = eret_v; tvec = tvec_v; epc = epc_v; cause = cause_v;
    redir.redirect_ready = 1'($urandom);
    @(negedge clk);
    if (ex_v && m_in_handler) begin
      check_eq("dbl_halt",  32'(halt), 32'd1);
      check_eq("dbl_stall", 32'(stall), 32'd1);
      check_eq("dbl_flush", 32'(flush), 32'd0);
      check_eq("dbl_valid", 32'(redir.redirect_valid), 32'd0);
      ex = 1'b0; eret = 1'b0;
      $display("txn double-fault t=%0t", $time);
      return;
    end
    if (!ex_v && !eret_v) begin
      check_idle_outputs("idle");
      check_eq("idle_taken", 32'(trap_taken), 32'd0);
      return;
    end
    is_trap = ex_v;
    exp_pc  = (is_trap ? tvec_v : epc_v) & ~32'h3;
    for (int i = 0; i < FC; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("fl_flush", 32'(flush), 32'd1);
      check_eq("fl_stall", 32'(stall), 32'd1);
      check_eq("fl_valid", 32'(redir.redirect_valid), 32'd0);
      garbage();
      redir.redirect_ready = 1'($urandom);
    end
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      check_eq("rd_valid", 32'(redir.redirect_valid), 32'd1);
      check_eq("rd_pc",    redir.redirect_pc, exp_pc);
      check_eq("rd_flush", 32'(flush), 32'd0);
      check_eq("rd_stall", 32'(stall), 32'd1);
      garbage();
      redir.redirect_ready = (i == delay);
    end
    @(negedge clk);
    ex = 1'b0; eret = 1'b0; redir.redirect_ready = 1'b0;
    if (is_trap) begin
      m_in_handler = 1'b1;
      m_cause      = cause_v;
      if (m_count < CMAX) m_count++;
    end else begin
      m_in_handler = 1'b0;
    end
    check_eq("hs_valid", 32'(redir.redirect_valid), 32'd0);
    check_eq("hs_stall", 32'(stall), 32'd0);
    check_eq("hs_taken", 32'(trap_taken), 32'(is_trap));
    check_eq("hs_inh",   32'(in_handler), 32'(m_in_handler));
    check_eq("hs_cnt",   32'(trap_count), 32'(m_count));
    check_eq("hs_cause", cause_q, m_cause);
    @(negedge clk);
    check_eq("taken_pulse", 32'(trap_taken), 32'd0);
    $display("txn %s pc=0x%0h delay=%0d cnt=%0d t=%0t", is_trap ? "trap" : "mret", exp_pc, delay, m_count, $time);
  endtask

  initial begin
    redir.redirect_ready = 1'b0;
    do_reset();

    // Directed: trap, stalled mret, simultaneous ex+eret, misaligned vector.
    run_event(1'b1, 1'b0, 32'h100, 32'h0,  32'd2, 0);
    run_event(1'b0, 1'b1, 32'h0,   32'h2C, 32'd0, 3);
    run_event(1'b1, 1'b1, 32'h80,  32'h40, 32'd7, 1);
    run_event(1'b0, 1'b1, 32'h0,   32'h44, 32'd0, 0);
    run_event(1'b1, 1'b0, 32'h103, 32'h0,  32'd9, 2);
    run_event(1'b0, 1'b1, 32'h0,   32'h10, 32'd0, 0);
    run_event(1'b0, 1'b1, 32'h0,   32'h77, 32'd0, 1);

    // Random traffic; enough traps to drive the counter into saturation.
    for (int n = 0; n < 60; n++) begin
      logic ex_r, eret_r;
      if (m_in_handler) begin
        ex_r = 1'b0; eret_r = ($urandom_range(0, 3) != 0);
      end else begin
        ex_r = ($urandom_range(0, 3) != 0); eret_r = 1'($urandom);
      end
      run_event(ex_r, eret_r, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
    while (m_count < CMAX || m_in_handler) begin
      if (m_in_handler) run_event(1'b0, 1'b1, 32'h0, $urandom, 32'h0, 0);
      else              run_event(1'b1, 1'b0, $urandom, 32'h0, $urandom, 0);
    end
    run_event(1'b1, 1'b0, 32'h200, 32'h0, 32'd5, 0);
    check_eq("sat_cnt", 32'(trap_count), 32'(CMAX));

    // Double fault: sticky halt ignoring inputs, then reset clears it.
    run_event(1'b1, 1'b0, 32'h300, 32'h0, 32'd11, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("halt_hold",  32'(halt), 32'd1);
      check_eq("halt_flush", 32'(flush), 32'd0);
      check_eq("halt_valid", 32'(redir.redirect_valid), 32'd0);
      garbage();
      redir.redirect_ready = 1'($urandom);
    end
    do_reset();

    // Reset in the second flush cycle, then a clean sequence.
    @(negedge clk);
    ex = 1'b1; tvec = 32'h400; cause = 32'd3;
    @(negedge clk);
    check_eq("mid_fl1", 32'(flush), 32'd1);
    ex = 1'b0;
    @(negedge clk);
    check_eq("mid_fl2", 32'(flush), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    check_eq("mid_cause", cause_q, 32'd0);
    rst = 1'b1;
    run_event(1'b1, 1'b0, 32'h500, 32'h0, 32'd4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
